// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;

    localparam int CPB_W = 18;
    localparam logic [CPB_W-1:0] CPB_DEFAULT = 18'd434;

    localparam int WDOG_W          = CPB_W + 4;
    localparam int WDOG_ACT_LIMIT  = 4;
    localparam int WDOG_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACT  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[IDX_W'(cand)]) begin
                any = 1'b1;
                idx = IDX_W'(cand);
            end
        end
        gnt = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin frame scheduler sharing one UART transmitter among NUM_REQ requesters.
// Define UART_TX_SCHED_WDOG_EN to enable the WAIT_ACT/WAIT_DONE watchdog.
//
// state     | meaning
// IDLE      | waiting for a request with the transmitter idle
// LAUNCH    | start strobe and accept pulse are out for this cycle
// WAIT_ACT  | waiting for the transmitter to report activity
// WAIT_DONE | frame in flight, waiting for the done pulse
module uart_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CPB_W   = uart_pkg::CPB_W,
    parameter logic [CPB_W-1:0] CPB_DEFAULT = CPB_W'(uart_pkg::CPB_DEFAULT)
) (
    input  logic                       internal_clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [CPB_W-1:0]           cfg_clk_per_bit,
    input  logic                       cfg_load,
    output logic [DATA_W-1:0]          tx_byte,
    output logic                       tx_enable_n,
    output logic [CPB_W-1:0]           tx_clk_per_bit,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       wdog_err
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [IDX_W-1:0]   ptr_next;
    logic               cfg_ok;
    logic               cfg_pend;
    logic [CPB_W-1:0]   cfg_pend_val;
    logic               cfg_apply;
    logic [CPB_W-1:0]   cfg_next_cpb;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

    // Values 0 and 1 cannot form a bit period and are discarded.
    assign cfg_ok       = cfg_load && (cfg_clk_per_bit > CPB_W'(1));
    assign cfg_apply    = cfg_ok || cfg_pend;
    assign cfg_next_cpb = cfg_ok ? cfg_clk_per_bit : cfg_pend_val;

`ifdef UART_TX_SCHED_WDOG_EN
    localparam int WD_W = CPB_W + 4;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_done_lim;
    assign wd_done_lim = WD_W'(tx_clk_per_bit) * WD_W'(WDOG_FRAME_BITS);
`else
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_ready      <= '0;
            tx_byte        <= '0;
            tx_enable_n    <= 1'b1;
            tx_clk_per_bit <= CPB_DEFAULT;
            busy           <= 1'b0;
            grant_id       <= '0;
            rr_ptr         <= '0;
            cfg_pend       <= 1'b0;
            cfg_pend_val   <= CPB_DEFAULT;
`ifdef UART_TX_SCHED_WDOG_EN
            wd_cnt         <= '0;
            wdog_err       <= 1'b0;
`endif
        end else begin
            // Loads outside the open IDLE window are parked; IDLE entry overrides below.
            if (cfg_ok) begin
                cfg_pend     <= 1'b1;
                cfg_pend_val <= cfg_clk_per_bit;
            end
            case (state)
                IDLE: begin
                    if (arb_any && !tx_active) begin
                        tx_byte     <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
                        req_ready   <= arb_gnt;
                        tx_enable_n <= 1'b0;
                        grant_id    <= arb_idx;
                        rr_ptr      <= ptr_next;
                        busy        <= 1'b1;
                        state       <= LAUNCH;
                    end else begin
                        if (cfg_apply) tx_clk_per_bit <= cfg_next_cpb;
                        cfg_pend <= 1'b0;
                    end
                end
                LAUNCH: begin
                    tx_enable_n <= 1'b1;
                    req_ready   <= '0;
                    state       <= WAIT_ACT;
`ifdef UART_TX_SCHED_WDOG_EN
                    wd_cnt      <= '0;
`endif
                end
                WAIT_ACT: begin
                    if (tx_active) begin
                        state <= WAIT_DONE;
`ifdef UART_TX_SCHED_WDOG_EN
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_W'(WDOG_ACT_LIMIT - 1)) begin
                        wdog_err <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        if (cfg_apply) tx_clk_per_bit <= cfg_next_cpb;
                        cfg_pend <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (cfg_apply) tx_clk_per_bit <= cfg_next_cpb;
                        cfg_pend <= 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
                        wd_cnt <= '0;
                    end else if (wd_cnt == wd_done_lim - 1'b1) begin
                        wdog_err <= 1'b1;
                        wd_cnt   <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                        if (cfg_apply) tx_clk_per_bit <= cfg_next_cpb;
                        cfg_pend <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler; define UART_TX_SCHED_WDOG_EN to cover the watchdog.
module tb_uart_tx_scheduler;

    logic        internal_clock;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [17:0] cfg_clk_per_bit;
    logic        cfg_load;
    logic [7:0]  tx_byte;
    logic        tx_enable_n;
    logic [17:0] tx_clk_per_bit;
    logic        tx_active;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        wdog_err;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_scheduler dut (
        .internal_clock  (internal_clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .cfg_clk_per_bit (cfg_clk_per_bit),
        .cfg_load        (cfg_load),
        .tx_byte         (tx_byte),
        .tx_enable_n     (tx_enable_n),
        .tx_clk_per_bit  (tx_clk_per_bit),
        .tx_active       (tx_active),
        .tx_done         (tx_done),
        .busy            (busy),
        .grant_id        (grant_id),
        .wdog_err        (wdog_err)
    );

    initial internal_clock = 1'b0;
    always #5 internal_clock = ~internal_clock;

    task automatic tick();
        @(posedge internal_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // One complete frame starting from IDLE with requests already presented.
    task automatic frame(input string tag, input int exp_g, input logic [7:0] exp_b,
                         input bit drop, input int done_wait);
        tick();
        check({tag, " launch ready"}, req_ready, 32'(4'b0001 << exp_g));
        check({tag, " launch strobe"}, tx_enable_n, 0);
        check({tag, " launch byte"}, tx_byte, exp_b);
        check({tag, " launch grant_id"}, grant_id, exp_g);
        check({tag, " launch busy"}, busy, 1);
        if (drop) req_valid[exp_g] = 1'b0;
        tick();
        check({tag, " strobe released"}, tx_enable_n, 1);
        check({tag, " ready released"}, req_ready, 0);
        tx_active = 1'b1;
        tick();
        repeat (done_wait) tick();
        check({tag, " byte held"}, tx_byte, exp_b);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        tick();
        tx_done = 1'b0;
        check({tag, " idle after done"}, busy, 0);
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = 4'b0000;
        req_data        = 32'h0;
        cfg_clk_per_bit = 18'd0;
        cfg_load        = 1'b0;
        tx_active       = 1'b0;
        tx_done         = 1'b0;
        do_reset();

        check("rst req_ready", req_ready, 0);
        check("rst tx_byte", tx_byte, 0);
        check("rst tx_enable_n", tx_enable_n, 1);
        check("rst cpb", tx_clk_per_bit, 434);
        check("rst busy", busy, 0);
        check("rst grant_id", grant_id, 0);
        check("rst wdog_err", wdog_err, 0);

        // Single requester, granted on consecutive frames.
        req_data  = 32'h0000_0055;
        req_valid = 4'b0001;
        frame("single1", 0, 8'h55, 1'b1, 3);
        tick();
        check("single no relaunch", tx_enable_n, 1);
        req_valid = 4'b0001;
        frame("single2", 0, 8'h55, 1'b1, 1);

        // All four valid continuously: strict rotation from pointer 0.
        do_reset();
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'b1111;
        frame("rr0", 0, 8'hA0, 1'b0, 2);
        frame("rr1", 1, 8'hA1, 1'b0, 2);
        frame("rr2", 2, 8'hA2, 1'b0, 2);
        frame("rr3", 3, 8'hA3, 1'b0, 2);
        frame("rr4", 0, 8'hA0, 1'b0, 2);
        req_valid = 4'b0000;
        tick();
        check("rr stop", tx_enable_n, 1);

        // Config load during WAIT_DONE deferred to end of frame; withdrawn request ignored.
        req_data  = 32'h0000_0011;
        req_valid = 4'b0001;
        tick();
        check("cfg frame launch", tx_enable_n, 0);
        req_valid = 4'b0000;
        tick();
        tx_active = 1'b1;
        tick();
        cfg_clk_per_bit = 18'd87;
        cfg_load        = 1'b1;
        tick();
        cfg_load  = 1'b0;
        req_valid = 4'b0100;
        check("cfg pending hold a", tx_clk_per_bit, 434);
        tick();
        req_valid = 4'b0000;
        check("cfg pending hold b", tx_clk_per_bit, 434);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        tick();
        tx_done = 1'b0;
        check("cfg applied at idle", tx_clk_per_bit, 87);
        tick();
        check("withdrawn not granted", tx_enable_n, 1);
        check("withdrawn busy", busy, 0);

        // Ignored values and an immediate load in IDLE.
        cfg_clk_per_bit = 18'd1;
        cfg_load        = 1'b1;
        tick();
        check("cfg 1 ignored", tx_clk_per_bit, 87);
        cfg_clk_per_bit = 18'd0;
        tick();
        check("cfg 0 ignored", tx_clk_per_bit, 87);
        cfg_clk_per_bit = 18'd200;
        tick();
        cfg_load = 1'b0;
        check("cfg idle load", tx_clk_per_bit, 200);

        // Load coincident with a launch waits for that frame to finish.
        req_valid       = 4'b0001;
        cfg_clk_per_bit = 18'd300;
        cfg_load        = 1'b1;
        tick();
        cfg_load  = 1'b0;
        req_valid = 4'b0000;
        check("cfg launch strobe", tx_enable_n, 0);
        check("cfg launch deferred", tx_clk_per_bit, 200);
        tick();
        tx_active = 1'b1;
        tick();
        tick();
        check("cfg launch still deferred", tx_clk_per_bit, 200);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        tick();
        tx_done = 1'b0;
        check("cfg launch applied", tx_clk_per_bit, 300);

        // Transmitter still active across our reset blocks the first launch.
        reset_n   = 1'b0;
        tx_active = 1'b1;
        req_data  = 32'h005A_0000;
        req_valid = 4'b0100;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("blocked strobe", tx_enable_n, 1);
        check("blocked busy", busy, 0);
        check("blocked ready", req_ready, 0);
        tx_active = 1'b0;
        tick();
        check("unblocked strobe", tx_enable_n, 0);
        check("unblocked ready", req_ready, 4'b0100);
        check("unblocked grant_id", grant_id, 2);
        req_valid = 4'b0000;
        tick();
        tx_active = 1'b1;
        tick();
        tick();
        check("mid busy", busy, 1);

        // Asynchronous reset in the middle of WAIT_DONE.
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst strobe", tx_enable_n, 1);
        check("async rst busy", busy, 0);
        check("async rst byte", tx_byte, 0);
        check("async rst grant_id", grant_id, 0);
        check("async rst cpb", tx_clk_per_bit, 434);
        check("async rst ready", req_ready, 0);
        tx_active = 1'b0;
        @(posedge internal_clock);
        #1;
        reset_n = 1'b1;
        tick();

`ifdef UART_TX_SCHED_WDOG_EN
        // Transmitter never becomes active: WAIT_ACT gives up after 4 cycles.
        cfg_clk_per_bit = 18'd10;
        cfg_load        = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("wd cpb 10", tx_clk_per_bit, 10);
        req_data  = 32'h0000_0033;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        repeat (3) tick();
        check("wd act busy before", busy, 1);
        check("wd act err before", wdog_err, 0);
        tick();
        check("wd act busy after", busy, 0);
        check("wd act err after", wdog_err, 1);

        // Frame never completes: WAIT_DONE gives up after 11*10 cycles.
        do_reset();
        check("wd err cleared", wdog_err, 0);
        cfg_clk_per_bit = 18'd10;
        cfg_load        = 1'b1;
        tick();
        cfg_load  = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tx_active = 1'b1;
        tick();
        repeat (109) tick();
        check("wd done err before", wdog_err, 0);
        check("wd done busy before", busy, 1);
        tick();
        check("wd done err after", wdog_err, 1);
        check("wd done busy after", busy, 0);
        tx_active = 1'b0;
        tick();
        tick();
        check("wd err sticky", wdog_err, 1);
`else
        // Without the watchdog a stalled transmitter is waited on indefinitely.
        req_data  = 32'h0000_0033;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        repeat (50) tick();
        check("no wd still busy", busy, 1);
        check("no wd err", wdog_err, 0);
        tx_active = 1'b1;
        tick();
        repeat (200) tick();
        check("no wd still waiting", busy, 1);
        tx_done   = 1'b1;
        tx_active = 1'b0;
        tick();
        tx_done = 1'b0;
        check("no wd idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
